// File: rtl/timer_display_pkg.sv
// Shared constants, payload types and the seven-segment decoder for the
// MM:SS timer overlay.
package timer_display_pkg;

    localparam int unsigned COORD_W     = 10;
    localparam int unsigned CELL_W      = 8;
    localparam int unsigned CELL_W_LOG2 = 3;
    localparam int unsigned CELL_H      = 16;
    localparam int unsigned N_CELLS     = 5;
    localparam int unsigned COLON_IDX   = 2;

    // Segment vector, bit order {g,f,e,d,c,b,a}
    typedef logic [6:0] seg_t;

    typedef struct packed {
        logic [2:0] min_ten;
        logic [3:0] min_one;
        logic [2:0] sec_ten;
        logic [3:0] sec_one;
    } digits_t;

    function automatic seg_t digit_to_seg(input logic [3:0] i_digit);
        seg_t v_seg;
        v_seg = 7'h00;
        case (i_digit)
            4'd0:    v_seg = 7'h3F;
            4'd1:    v_seg = 7'h06;
            4'd2:    v_seg = 7'h5B;
            4'd3:    v_seg = 7'h4F;
            4'd4:    v_seg = 7'h66;
            4'd5:    v_seg = 7'h6D;
            4'd6:    v_seg = 7'h7D;
            4'd7:    v_seg = 7'h07;
            4'd8:    v_seg = 7'h7F;
            4'd9:    v_seg = 7'h6F;
            default: v_seg = 7'h00;
        endcase
        return v_seg;
    endfunction

endpackage

// File: rtl/timer_display_glyph.sv
// Combinational glyph lookup: decides whether an unscaled (col,row) inside
// an 8x16 cell is lit for a given segment set or for the colon cell.
module timer_glyph
    import timer_display_pkg::*;
(
    input  seg_t       i_seg,
    input  logic       i_is_colon,
    input  logic [2:0] i_col,
    input  logic [3:0] i_row,
    output logic       o_hit_c
);

    logic w_hcol;
    logic w_upper;
    logic w_lower;
    logic w_colon_col;
    logic w_colon_row;
    seg_t w_seg_at;

    assign w_hcol      = (i_col >= 3'd1) && (i_col <= 3'd6);
    assign w_upper     = (i_row >= 4'd1) && (i_row <= 4'd7);
    assign w_lower     = (i_row >= 4'd8) && (i_row <= 4'd14);
    assign w_colon_col = (i_col == 3'd3) || (i_col == 3'd4);
    assign w_colon_row = (i_row == 4'd4) || (i_row == 4'd5)
                      || (i_row == 4'd10) || (i_row == 4'd11);

    // Which segment (if any) covers this pixel, same bit order as seg_t
    always_comb begin
        w_seg_at    = '0;
        w_seg_at[0] = (i_row == 4'd1)  && w_hcol;
        w_seg_at[1] = (i_col == 3'd6)  && w_upper;
        w_seg_at[2] = (i_col == 3'd6)  && w_lower;
        w_seg_at[3] = (i_row == 4'd14) && w_hcol;
        w_seg_at[4] = (i_col == 3'd1)  && w_lower;
        w_seg_at[5] = (i_col == 3'd1)  && w_upper;
        w_seg_at[6] = (i_row == 4'd7)  && w_hcol;
    end

    assign o_hit_c = i_is_colon ? (w_colon_col && w_colon_row)
                                : (|(i_seg & w_seg_at));

endmodule

// File: rtl/timer_display.sv
// Scaled MM:SS seven-segment overlay for the VGA stream, with a digit
// snapshot and busy handshake that keeps the timer frozen across the band.
module timer_display
    import timer_display_pkg::*;
#(
    parameter logic [COORD_W-1:0] X0         = 10'd256,
    parameter logic [COORD_W-1:0] Y0         = 10'd16,
    parameter int unsigned        SCALE_LOG2 = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic               i_pixel_valid,
    input  logic [2:0]         i_min_ten,
    input  logic [3:0]         i_min_one,
    input  logic [2:0]         i_sec_ten,
    input  logic [3:0]         i_sec_one,
    output logic               o_VGA_buzy,
    output logic               o_pixel_on,
    output logic               o_pixel_valid
);

    localparam int unsigned EXT_W = COORD_W + 1;
    localparam int unsigned OV_W  = (CELL_W * N_CELLS) << SCALE_LOG2;
    localparam int unsigned OV_H  = CELL_H << SCALE_LOG2;
    localparam logic [EXT_W-1:0] Y_END = EXT_W'(Y0) + EXT_W'(OV_H);

    logic               w_band;
    logic [COORD_W-1:0] w_rx;
    logic [COORD_W-1:0] w_ry;
    logic               w_in_region;
    logic [2:0]         w_char;
    logic [2:0]         w_col;
    logic [3:0]         w_row;
    digits_t            w_digits_in;

    logic               r_busy;
    logic [1:0]         r_tail;
    digits_t            r_snap;

    logic               r_s1_in_region;
    logic [2:0]         r_s1_char;
    logic [2:0]         r_s1_col;
    logic [3:0]         r_s1_row;
    logic               r_s1_valid;

    logic [3:0]         w_digit;
    logic               w_blank;
    seg_t               w_seg;
    logic               w_is_colon;
    logic               w_hit;

    logic               r_pixel_on;
    logic               r_pixel_valid;

    assign w_band = (i_y >= Y0) && (EXT_W'(i_y) < Y_END);

    // Offsets wrap; the i_x >= X0 term keeps wrapped columns out of the region
    assign w_rx        = i_x - X0;
    assign w_ry        = i_y - Y0;
    assign w_in_region = (i_x >= X0) && (EXT_W'(w_rx) < EXT_W'(OV_W))
                      && w_band && i_pixel_valid;
    assign w_char      = 3'(w_rx >> (SCALE_LOG2 + CELL_W_LOG2));
    assign w_col       = 3'(w_rx >> SCALE_LOG2);
    assign w_row       = 4'(w_ry >> SCALE_LOG2);

    assign w_digits_in = '{min_ten: i_min_ten, min_one: i_min_one,
                           sec_ten: i_sec_ten, sec_one: i_sec_one};

    // Busy stays up for the band plus two drain cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_tail <= 2'd0;
        end else begin
            r_busy <= w_band || (r_tail != 2'd0);
            if (w_band) begin
                r_tail <= 2'd2;
            end else if (r_tail != 2'd0) begin
                r_tail <= r_tail - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap <= '0;
        end else if (!w_band && !r_busy) begin
            r_snap <= w_digits_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_in_region <= 1'b0;
            r_s1_char      <= 3'd0;
            r_s1_col       <= 3'd0;
            r_s1_row       <= 4'd0;
            r_s1_valid     <= 1'b0;
        end else begin
            r_s1_in_region <= w_in_region;
            r_s1_char      <= w_char;
            r_s1_col       <= w_col;
            r_s1_row       <= w_row;
            r_s1_valid     <= i_pixel_valid;
        end
    end

    // Tens digits only go to 5; 6 and 7 render blank like out-of-range units
    always_comb begin
        w_digit = 4'd0;
        w_blank = 1'b1;
        case (r_s1_char)
            3'd0: begin
                w_digit = {1'b0, r_snap.min_ten};
                w_blank = (r_snap.min_ten > 3'd5);
            end
            3'd1: begin
                w_digit = r_snap.min_one;
                w_blank = 1'b0;
            end
            3'd3: begin
                w_digit = {1'b0, r_snap.sec_ten};
                w_blank = (r_snap.sec_ten > 3'd5);
            end
            3'd4: begin
                w_digit = r_snap.sec_one;
                w_blank = 1'b0;
            end
            default: begin
                w_digit = 4'd0;
                w_blank = 1'b1;
            end
        endcase
    end

    assign w_seg      = w_blank ? seg_t'(0) : digit_to_seg(w_digit);
    assign w_is_colon = (r_s1_char == 3'(COLON_IDX));

    timer_glyph u_glyph (
        .i_seg      (w_seg),
        .i_is_colon (w_is_colon),
        .i_col      (r_s1_col),
        .i_row      (r_s1_row),
        .o_hit_c    (w_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pixel_on    <= 1'b0;
            r_pixel_valid <= 1'b0;
        end else begin
            r_pixel_on    <= r_s1_in_region && w_hit;
            r_pixel_valid <= r_s1_valid;
        end
    end

    assign o_VGA_buzy    = r_busy;
    assign o_pixel_on    = r_pixel_on;
    assign o_pixel_valid = r_pixel_valid;

endmodule

// File: tb/tb_timer_display.sv
// Directed bench for timer_display: three instances cover the default
// placement at x2 scale, x1 scale, and an overlay anchored near the right edge.
module tb_timer_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] i_x;
    logic [9:0] i_y;
    logic       i_pixel_valid;
    logic [2:0] i_min_ten;
    logic [3:0] i_min_one;
    logic [2:0] i_sec_ten;
    logic [3:0] i_sec_one;

    logic busy_a, on_a, pv_a;
    logic busy_b, on_b, pv_b;
    logic busy_c, on_c, pv_c;

    int n_cmp  = 0;
    int n_fail = 0;

    logic pix_a   [0:55][0:87];
    logic busy_tr [0:4927];

    always #5 clk = ~clk;

    timer_display #(.X0(10'd256), .Y0(10'd16), .SCALE_LOG2(1)) dut_a (
        .clk(clk), .rst(rst), .i_x(i_x), .i_y(i_y), .i_pixel_valid(i_pixel_valid),
        .i_min_ten(i_min_ten), .i_min_one(i_min_one),
        .i_sec_ten(i_sec_ten), .i_sec_one(i_sec_one),
        .o_VGA_buzy(busy_a), .o_pixel_on(on_a), .o_pixel_valid(pv_a));

    timer_display #(.X0(10'd256), .Y0(10'd16), .SCALE_LOG2(0)) dut_b (
        .clk(clk), .rst(rst), .i_x(i_x), .i_y(i_y), .i_pixel_valid(i_pixel_valid),
        .i_min_ten(i_min_ten), .i_min_one(i_min_one),
        .i_sec_ten(i_sec_ten), .i_sec_one(i_sec_one),
        .o_VGA_buzy(busy_b), .o_pixel_on(on_b), .o_pixel_valid(pv_b));

    timer_display #(.X0(10'd1000), .Y0(10'd16), .SCALE_LOG2(0)) dut_c (
        .clk(clk), .rst(rst), .i_x(i_x), .i_y(i_y), .i_pixel_valid(i_pixel_valid),
        .i_min_ten(i_min_ten), .i_min_one(i_min_one),
        .i_sec_ten(i_sec_ten), .i_sec_one(i_sec_one),
        .o_VGA_buzy(busy_c), .o_pixel_on(on_c), .o_pixel_valid(pv_c));

    task automatic set_digits(input int mt, input int mo, input int st, input int so);
        i_min_ten = 3'(mt);
        i_min_one = 4'(mo);
        i_sec_ten = 3'(st);
        i_sec_one = 4'(so);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            i_x = 10'd0; i_y = 10'd0; i_pixel_valid = 1'b0;
        end
    endtask

    // Drive one pixel and hold it; outputs on return belong to that pixel
    task automatic probe(input int x, input int y, input logic v);
        @(negedge clk);
        i_x = 10'(x); i_y = 10'(y); i_pixel_valid = v;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Raster rows 0..55, columns 252..339; records busy and pixel per drive
    task automatic scan_frame(input bit chg);
        int n;
        n = 0;
        for (int y = 0; y < 56; y++) begin
            for (int xi = 0; xi < 88; xi++) begin
                @(negedge clk);
                if (n >= 1) busy_tr[n-1] = busy_a;
                if (n >= 2) pix_a[(n-2)/88][(n-2)%88] = on_a;
                if (chg && y == 30 && xi == 0) set_digits(5, 9, 5, 9);
                i_x = 10'(252 + xi); i_y = 10'(y); i_pixel_valid = 1'b1;
                n++;
            end
        end
        @(negedge clk);
        busy_tr[n-1] = busy_a;
        pix_a[(n-2)/88][(n-2)%88] = on_a;
        @(negedge clk);
        pix_a[(n-1)/88][(n-1)%88] = on_a;
    endtask

    // Probe each segment centre of cell k in the x2 capture: {g,f,e,d,c,b,a}
    function automatic logic [6:0] decode_cell(input int k);
        int bx;
        bx = 4 + k * 16;
        return {pix_a[16+14][bx+6],  pix_a[16+8][bx+2],  pix_a[16+22][bx+2],
                pix_a[16+28][bx+6],  pix_a[16+22][bx+12], pix_a[16+8][bx+12],
                pix_a[16+2][bx+6]};
    endfunction

    // Colon probes: (3,4) (4,10) lit; (3,7) (1,4) dark
    function automatic logic [3:0] decode_colon();
        int bx;
        bx = 4 + 2 * 16;
        return {pix_a[16+8][bx+6], pix_a[16+20][bx+8],
                pix_a[16+14][bx+6], pix_a[16+8][bx+2]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        set_digits(1, 1, 1, 1);
        i_x = 10'd0; i_y = 10'd20; i_pixel_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        n_cmp++;
        if ({busy_a, on_a, pv_a} !== 3'b000) begin
            n_fail++; $display("FAIL reset_a got=%b exp=000", {busy_a, on_a, pv_a});
        end
        n_cmp++;
        if ({busy_b, on_b, pv_b, busy_c, on_c, pv_c} !== 6'b0) begin
            n_fail++; $display("FAIL reset_bc got=%b exp=000000", {busy_b, on_b, pv_b, busy_c, on_c, pv_c});
        end
        rst = 1'b0;
        // Still in band: snapshot keeps its reset value, so cell 0 shows "0" (seg a lit)
        probe(256 + 6, 16 + 2, 1'b1);
        n_cmp++;
        if (on_a !== 1'b1) begin
            n_fail++; $display("FAIL reset_shows_zero got=%b exp=1", on_a);
        end
        n_cmp++;
        if (busy_a !== 1'b1) begin
            n_fail++; $display("FAIL reset_band_busy got=%b exp=1", busy_a);
        end
    endtask

    task automatic test_frame();
        int zeros;
        logic any_on;
        set_digits(1, 2, 3, 4);
        scan_frame(1'b1);
        n_cmp++;
        if (busy_tr[15*88+87] !== 1'b0) begin
            n_fail++; $display("FAIL busy_before_band got=%b exp=0", busy_tr[15*88+87]);
        end
        n_cmp++;
        if (busy_tr[16*88] !== 1'b1) begin
            n_fail++; $display("FAIL busy_band_start got=%b exp=1", busy_tr[16*88]);
        end
        zeros = 0;
        for (int n = 16*88; n <= 48*88+1; n++) if (busy_tr[n] !== 1'b1) zeros++;
        n_cmp++;
        if (zeros !== 0) begin
            n_fail++; $display("FAIL busy_held got=%0d low samples exp=0", zeros);
        end
        n_cmp++;
        if (busy_tr[48*88+2] !== 1'b0) begin
            n_fail++; $display("FAIL busy_drop got=%b exp=0", busy_tr[48*88+2]);
        end
        n_cmp++;
        if ({decode_cell(0), decode_cell(1), decode_cell(3), decode_cell(4)} !==
            {7'h06, 7'h5B, 7'h4F, 7'h66}) begin
            n_fail++; $display("FAIL frame1_12_34 got=%h %h %h %h exp=06 5b 4f 66",
                decode_cell(0), decode_cell(1), decode_cell(3), decode_cell(4));
        end
        n_cmp++;
        if (decode_colon() !== 4'b1100) begin
            n_fail++; $display("FAIL colon got=%b exp=1100", decode_colon());
        end
        any_on = 1'b0;
        for (int y = 0; y < 56; y++)
            if (y < 16 || y >= 48)
                for (int xi = 0; xi < 88; xi++) any_on = any_on | pix_a[y][xi];
        n_cmp++;
        if (any_on !== 1'b0) begin
            n_fail++; $display("FAIL outside_band got=%b exp=0", any_on);
        end
        scan_frame(1'b0);
        n_cmp++;
        if ({decode_cell(0), decode_cell(1), decode_cell(3), decode_cell(4)} !==
            {7'h6D, 7'h6F, 7'h6D, 7'h6F}) begin
            n_fail++; $display("FAIL frame2_59_59 got=%h %h %h %h exp=6d 6f 6d 6f",
                decode_cell(0), decode_cell(1), decode_cell(3), decode_cell(4));
        end
    endtask

    task automatic test_out_of_range();
        logic any_on;
        set_digits(6, 3, 0, 12);
        scan_frame(1'b0);
        n_cmp++;
        if ({decode_cell(0), decode_cell(1), decode_cell(3), decode_cell(4)} !==
            {7'h00, 7'h4F, 7'h3F, 7'h00}) begin
            n_fail++; $display("FAIL range_cells got=%h %h %h %h exp=00 4f 3f 00",
                decode_cell(0), decode_cell(1), decode_cell(3), decode_cell(4));
        end
        any_on = 1'b0;
        for (int y = 16; y < 48; y++)
            for (int xi = 0; xi < 16; xi++)
                any_on = any_on | pix_a[y][4+xi] | pix_a[y][68+xi];
        n_cmp++;
        if (any_on !== 1'b0) begin
            n_fail++; $display("FAIL range_blank_cells got=%b exp=0", any_on);
        end
    endtask

    task automatic test_latency();
        set_digits(5, 9, 5, 9);
        idle(6);
        @(negedge clk);
        i_x = 10'(256 + 6); i_y = 10'(16 + 2); i_pixel_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({on_a, pv_a} !== 2'b00) begin
            n_fail++; $display("FAIL latency_early got=%b exp=00", {on_a, pv_a});
        end
        i_x = 10'd0; i_y = 10'd0; i_pixel_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({on_a, pv_a} !== 2'b11) begin
            n_fail++; $display("FAIL latency_two got=%b exp=11", {on_a, pv_a});
        end
        @(negedge clk);
        n_cmp++;
        if ({on_a, pv_a} !== 2'b00) begin
            n_fail++; $display("FAIL latency_after got=%b exp=00", {on_a, pv_a});
        end
        idle(4);
        probe(256 + 6, 16 + 2, 1'b0);
        n_cmp++;
        if ({on_a, pv_a} !== 2'b00) begin
            n_fail++; $display("FAIL invalid_pixel got=%b exp=00", {on_a, pv_a});
        end
    endtask

    task automatic test_edges();
        set_digits(5, 9, 5, 9);
        idle(6);
        probe(256 + 19, 16 + 4, 1'b1);
        n_cmp++;
        if (on_b !== 1'b1) begin
            n_fail++; $display("FAIL edge_colon got=%b exp=1", on_b);
        end
        probe(256 + 1, 16 + 1, 1'b1);
        n_cmp++;
        if (on_b !== 1'b1) begin
            n_fail++; $display("FAIL edge_first_col got=%b exp=1", on_b);
        end
        probe(256 - 1, 16 + 1, 1'b1);
        n_cmp++;
        if (on_b !== 1'b0) begin
            n_fail++; $display("FAIL edge_left got=%b exp=0", on_b);
        end
        probe(256 + 40, 16 + 1, 1'b1);
        n_cmp++;
        if (on_b !== 1'b0) begin
            n_fail++; $display("FAIL edge_right got=%b exp=0", on_b);
        end
        probe(256 + 65, 16 + 1, 1'b1);
        n_cmp++;
        if (on_b !== 1'b0) begin
            n_fail++; $display("FAIL edge_alias got=%b exp=0", on_b);
        end
        idle(4);
        probe(4, 16 + 1, 1'b1);
        n_cmp++;
        if (on_c !== 1'b0) begin
            n_fail++; $display("FAIL edge_wrap got=%b exp=0", on_c);
        end
        probe(1001, 16 + 1, 1'b1);
        n_cmp++;
        if (on_c !== 1'b1) begin
            n_fail++; $display("FAIL edge_right_anchor got=%b exp=1", on_c);
        end
    endtask

    task automatic test_async_reset();
        set_digits(5, 9, 5, 9);
        idle(6);
        probe(256 + 6, 16 + 2, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy_a, on_a, pv_a} !== 3'b000) begin
            n_fail++; $display("FAIL async_reset got=%b exp=000", {busy_a, on_a, pv_a});
        end
        @(negedge clk);
        rst = 1'b0;
        i_x = 10'd0; i_y = 10'd0; i_pixel_valid = 1'b0;
        set_digits(2, 3, 4, 5);
        @(negedge clk);
        n_cmp++;
        if (busy_a !== 1'b0) begin
            n_fail++; $display("FAIL release_busy got=%b exp=0", busy_a);
        end
        set_digits(0, 0, 0, 0);
        i_x = 10'(256 + 22); i_y = 10'(16 + 14); i_pixel_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (on_a !== 1'b1) begin
            n_fail++; $display("FAIL release_capture got=%b exp=1", on_a);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_out_of_range();
        test_latency();
        test_edges();
        test_async_reset();
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_display.md
# timer_display

Renders the match timer as a scaled "MM:SS" seven-segment overlay in the VGA pixel stream and drives the busy handshake back to `timer`. It sits directly downstream of `timer`: it consumes `o_min_ten/o_min_one/o_sec_ten/o_sec_one` and produces `o_VGA_buzy` for `timer`'s `i_VGA_buzy`. Its pixel output is ORed into the VGA colour mux. Digits are snapshotted outside the overlay band, so a frame never shows a torn value.

## Interface
- `X0`, 10'd256: left pixel column of the overlay.
- `Y0`, 10'd16: top pixel row of the overlay.
- `SCALE_LOG2`, 1: glyph magnification is 2^SCALE_LOG2, legal range 0..2.
- `clk`  input  1  system clock; one clock domain only.
- `rst`  input  1  reset, asynchronous and active-high.
- `i_x`  input  10  current pixel column from the VGA timing generator.
- `i_y`  input  10  current pixel row from the VGA timing generator.
- `i_pixel_valid`  input  1  `i_x`/`i_y` are in the active area.
- `i_min_ten`  input  3  from `timer.o_min_ten`.
- `i_min_one`  input  4  from `timer.o_min_one`.
- `i_sec_ten`  input  3  from `timer.o_sec_ten`.
- `i_sec_one`  input  4  from `timer.o_sec_one`.
- `o_VGA_buzy`  output  1  to `timer.i_VGA_buzy`; high = do not change the digits.
- `o_pixel_on`  output  1  overlay foreground at the delayed pixel.
- `o_pixel_valid`  output  1  `i_pixel_valid` delayed to align with `o_pixel_on`.

## Operation
- Cell size is 8x16 unscaled. There are 5 cells: `M` `M` `:` `S` `S`. The overlay is (40<<S) wide and (16<<S) tall, where S = SCALE_LOG2.
- **Band:** `band = (i_y >= Y0) && (i_y < Y0 + (16<<S))`, combinational. It ignores `i_x` and `i_pixel_valid`.
- **Snapshot:** a 14-bit register holding the four digits.
  - It loads from the `i_*` digits on every cycle where `band==0 && o_VGA_buzy==0`.
  - Otherwise it holds.
- **Busy:** `o_VGA_buzy <= band || (tail != 0)`.
  - `tail` is a 2-bit down-counter, loaded with 2 when `band` is high.
  - It decrements to 0 while `band` is low.
  - Busy therefore falls exactly 2 cycles after the band ends, which covers the pipeline drain.
- **Coordinates:**
  - `rx = i_x - X0` and `ry = i_y - Y0`, 10-bit unsigned.
  - The pixel is in the region iff `i_x >= X0 && rx < (40<<S) && band && i_pixel_valid`.
  - `char = rx >> (S+3)`, giving 0..4.
  - `col = (rx>>S) & 7`.
  - `row = (ry>>S) & 15`.
- **Segments** (col, row, unscaled):
  - a: row 1, cols 1-6
  - b: col 6, rows 1-7
  - c: col 6, rows 8-14
  - d: row 14, cols 1-6
  - e: col 1, rows 8-14
  - f: col 1, rows 1-7
  - g: row 7, cols 1-6
- **Digit map:** standard seven-segment patterns for 0-9. A value above 9 (min_one/sec_one), or above 5 (min_ten/sec_ten, i.e. 6 or 7), renders blank.
- **Colon cell:** lit at cols 3-4 on rows 4-5 and rows 10-11.
- Outside the region, `o_pixel_on` is 0.

## Timing
- Pipeline latency is 2 cycles from `i_x/i_y/i_pixel_valid` to `o_pixel_on/o_pixel_valid`.
  - Stage 1 registers `in_region`, `char`, `col`, `row` and `valid`.
  - Stage 2 registers glyph hit (AND in_region) and `valid`.
- `o_VGA_buzy` is registered and has 1-cycle latency from `band` rising.
  - `timer` reacts one cycle later again, so the digits are frozen at least one cycle before the first overlay pixel of the band.
  - The snapshot stops loading in the same cycle `band` rises.
- **Reset values:**
  - `o_VGA_buzy`=0, `o_pixel_on`=0, `o_pixel_valid`=0.
  - snapshot=0, so the display shows "00:00".
  - `tail`=0; pipeline registers are 0.
- **Reset mid-frame:** all state clears immediately and busy drops. On the first cycle after release, the snapshot reloads if the beam is outside the band; otherwise it shows "00:00" until the band ends.
- **X0 near the right edge:** `rx` is compared before wrap, so a pixel with `i_x < X0` is never in the region.
- **Band re-entry while tail≠0:** `tail` reloads to 2 and busy stays high continuously.

## Structure
- Package `timer_display_pkg` holds:
  - cell constants `CELL_W=8`, `CELL_H=16`, `N_CELLS=5`, `COLON_IDX=2`;
  - typedef `seg_t` (logic [6:0], order gfedcba);
  - function `digit_to_seg(logic [3:0])` returning `seg_t`, blank for >9.
- One sub-module, `timer_glyph`: combinational. Inputs are `seg_t`, `is_colon`, `col[2:0]` and `row[3:0]`; output is `hit`. It is instantiated once, at stage 2.
- The top level owns band/busy/tail, the snapshot, the stage-1 coordinate math and the pipeline registers.

## Test plan
- **Reset, then frame:** digits 1,2,3,4 and one frame scan with S=1 give busy=0 before `i_y`=16 and busy=1 from the cycle after `i_y`=16 to 2 cycles after `i_y`=48. The overlay decodes as "12:34".
- **Digit change during band:** change digits to 5,9,5,9 while `i_y`=30. The current frame still renders "12:34" and the next frame renders "59:59".
- **Out-of-range digits:** `i_min_ten`=6 and `i_sec_one`=12 render cell 0 and cell 4 as all 0. The other cells are normal.
- **Latency and valid:** a single valid pixel at (X0+6, Y0+2), segment a of cell 0 at S=1, gives `o_pixel_on`=1 and `o_pixel_valid`=1 exactly 2 cycles later. With `i_pixel_valid`=0 at the same coordinates, `o_pixel_on`=0.
- **Asynchronous reset:** assert `rst` mid-band for 1 cycle. All outputs are 0 within the same cycle. After release outside the band, the snapshot captures the current digits.
- **Region edges:** with S=0, `i_x`=X0-1 gives `o_pixel_on`=0. `i_x`=X0+40 gives 0 in the region row. Colon pixel (X0+19, Y0+4) gives 1.
